// File: rtl/fetch_ifid_stage_if.sv
// Fetch-stage bundle: icache request/response, hazard controls, EX redirect and IF/ID outputs.
interface fetch_ifid_stage_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        h_pcen;
  logic        ifid_pause;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        fetch_halted;

  // The fetch stage drives the icache request and the IF/ID outputs.
  modport master (
    input  ihit, imemload, h_pcen, ifid_pause, redirect, redirect_pc,
    output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid, fetch_halted
  );

  // The surrounding core: icache, hazard unit, EX and decode.
  modport slave (
    output ihit, imemload, h_pcen, ifid_pause, redirect, redirect_pc,
    input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid, fetch_halted
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch with PC, one-entry hold buffer and IF/ID pipeline latch.
module fetch_ifid_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic               clk,
  input  logic               rst,
  fetch_ifid_stage_if.master bus
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc, pc_n;
  logic [XLEN-1:0]   ifid_instr, ifid_instr_n;
  logic [XLEN-1:0]   ifid_npc, ifid_npc_n;
  logic              ifid_valid, ifid_valid_n;
  logic              fetch_halted, fetch_halted_n;
  logic [XLEN-1:0]   hold_instr, hold_instr_n;
  logic [XLEN-1:0]   hold_npc, hold_npc_n;

  logic              adv;
  logic [XLEN-1:0]   pc_plus4;
  logic              ifid_we;
  logic [XLEN-1:0]   wr_instr;
  logic [XLEN-1:0]   wr_npc;

  // State and pipeline registers; reset discards any buffered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= PC_INIT;
      ifid_instr   <= '0;
      ifid_npc     <= '0;
      ifid_valid   <= 1'b0;
      fetch_halted <= 1'b0;
      hold_instr   <= '0;
      hold_npc     <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      ifid_instr   <= ifid_instr_n;
      ifid_npc     <= ifid_npc_n;
      ifid_valid   <= ifid_valid_n;
      fetch_halted <= fetch_halted_n;
      hold_instr   <= hold_instr_n;
      hold_npc     <= hold_npc_n;
    end
  end

  // Next-state logic: redirect flushes, then halt, then normal fetch/hold handling.
  always_comb begin
    state_n        = state;
    pc_n           = pc;
    ifid_instr_n   = ifid_instr;
    ifid_npc_n     = ifid_npc;
    ifid_valid_n   = ifid_valid;
    fetch_halted_n = fetch_halted;
    hold_instr_n   = hold_instr;
    hold_npc_n     = hold_npc;
    adv            = bus.h_pcen & ~bus.ifid_pause;
    pc_plus4       = pc + XLEN'(4);
    ifid_we        = 1'b0;
    wr_instr       = '0;
    wr_npc         = '0;

    if (bus.redirect && (state != HALTED)) begin
      pc_n         = {bus.redirect_pc[XLEN-1:2], 2'b00};
      ifid_instr_n = '0;
      ifid_valid_n = 1'b0;
      hold_instr_n = '0;
      hold_npc_n   = '0;
      state_n      = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (bus.ihit) begin
            if (adv) begin
              ifid_we  = 1'b1;
              wr_instr = bus.imemload;
              wr_npc   = pc_plus4;
              pc_n     = pc_plus4;
            end else begin
              hold_instr_n = bus.imemload;
              hold_npc_n   = pc_plus4;
              state_n      = HOLD;
            end
          end else if (!bus.ifid_pause) begin
            ifid_instr_n = '0;
            ifid_valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (adv) begin
            ifid_we  = 1'b1;
            wr_instr = hold_instr;
            wr_npc   = hold_npc;
            pc_n     = pc_plus4;
            state_n  = FETCH;
          end
        end
        HALTED: begin
          if (!bus.ifid_pause) begin
            ifid_instr_n = '0;
            ifid_valid_n = 1'b0;
          end
        end
        default: state_n = FETCH;
      endcase

      // Latching a halt opcode stops fetch for good.
      if (ifid_we) begin
        ifid_instr_n = wr_instr;
        ifid_npc_n   = wr_npc;
        ifid_valid_n = 1'b1;
        if (wr_instr[OP_MSB:OP_LSB] == HALT_OP) begin
          state_n        = HALTED;
          fetch_halted_n = 1'b1;
        end
      end
    end
  end

  // A request is issued only while waiting on the icache and not being flushed.
  assign bus.imemREN      = (state == FETCH) & ~bus.redirect;
  assign bus.imemaddr     = pc;
  assign bus.ifid_instr   = ifid_instr;
  assign bus.ifid_npc     = ifid_npc;
  assign bus.ifid_valid   = ifid_valid;
  assign bus.fetch_halted = fetch_halted;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Self-checking bench for fetch_ifid_stage: directed scenarios then random traffic vs a queue-based model.
module tb_fetch_ifid_stage;

  localparam logic [5:0]  HALT_OP = 6'b111111;
  localparam logic [31:0] PC0     = 32'h0000_0000;
  localparam logic [31:0] PC1     = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst;

  fetch_ifid_stage_if bus0();
  fetch_ifid_stage_if bus1();

  fetch_ifid_stage #(.PC_INIT(PC0), .HALT_OP(HALT_OP)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  fetch_ifid_stage #(.PC_INIT(PC1), .HALT_OP(HALT_OP)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural PC, IF/ID contents, buffered words as a queue.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
  } word_t;

  logic [31:0] m_pc, m_instr, m_npc;
  logic        m_valid, m_halted;
  word_t       m_buf[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = PC0; m_instr = '0; m_npc = '0; m_valid = 1'b0; m_halted = 1'b0;
    m_buf.delete();
  endtask

  task automatic model_deliver(input logic [31:0] instr, input logic [31:0] npc);
    m_instr = instr; m_npc = npc; m_valid = 1'b1;
    m_pc = m_pc + 32'd4;
    if (instr[31:26] == HALT_OP) m_halted = 1'b1;
  endtask

  task automatic model_step(input logic ihit, input logic [31:0] load, input logic pcen,
                            input logic pause, input logic redir, input logic [31:0] rpc);
    logic  go;
    word_t w;
    go = pcen && !pause;
    if (m_halted) begin
      if (!pause) begin m_valid = 1'b0; m_instr = '0; end
    end else if (redir) begin
      m_pc = rpc & ~32'd3; m_valid = 1'b0; m_instr = '0;
      m_buf.delete();
    end else if (m_buf.size() != 0) begin
      if (go) begin
        w = m_buf.pop_front();
        model_deliver(w.instr, w.npc);
      end
    end else if (ihit) begin
      if (go) model_deliver(load, m_pc + 32'd4);
      else begin
        w.instr = load; w.npc = m_pc + 32'd4;
        m_buf.push_back(w);
      end
    end else if (!pause) begin
      m_valid = 1'b0; m_instr = '0;
    end
  endtask

  task automatic check_regs();
    check("imemaddr",     bus0.imemaddr,            m_pc);
    check("ifid_instr",   bus0.ifid_instr,          m_instr);
    check("ifid_npc",     bus0.ifid_npc,            m_npc);
    check("ifid_valid",   32'(bus0.ifid_valid),     32'(m_valid));
    check("fetch_halted", 32'(bus0.fetch_halted),   32'(m_halted));
  endtask

  // Drive one cycle: check the combinational request, clock, then check registered state.
  task automatic do_cycle(input logic ihit, input logic [31:0] load, input logic pcen,
                          input logic pause, input logic redir, input logic [31:0] rpc);
    bus0.ihit = ihit; bus0.imemload = load; bus0.h_pcen = pcen;
    bus0.ifid_pause = pause; bus0.redirect = redir; bus0.redirect_pc = rpc;
    #1;
    check("imemREN", 32'(bus0.imemREN), 32'(!m_halted && m_buf.size() == 0 && !redir));
    check("imemaddr_pre", bus0.imemaddr, m_pc);
    @(posedge clk);
    model_step(ihit, load, pcen, pause, redir, rpc);
    #1;
    check_regs();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    bus0.ihit = 1'b0; bus0.imemload = '0; bus0.h_pcen = 1'b0;
    bus0.ifid_pause = 1'b0; bus0.redirect = 1'b0; bus0.redirect_pc = '0;
    rst = 1'b1;
    #1;
    model_reset();
    check_regs();
    check("imemREN_rst", 32'(bus0.imemREN), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == HALT_OP) w[26] = 1'b0;
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b0;
    bus1.ihit = 1'b0; bus1.imemload = '0; bus1.h_pcen = 1'b0;
    bus1.ifid_pause = 1'b0; bus1.redirect = 1'b0; bus1.redirect_pc = '0;
    do_reset();

    // PC wrap at the top of the address space on the second instance.
    check("wrap_addr0", bus1.imemaddr, PC1);
    bus1.ihit = 1'b1; bus1.imemload = 32'h1234_5678; bus1.h_pcen = 1'b1;
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    check("wrap_npc",   bus1.ifid_npc,          32'h0);
    check("wrap_addr",  bus1.imemaddr,          32'h0);
    check("wrap_valid", 32'(bus1.ifid_valid),   32'd1);
    check("wrap_instr", bus1.ifid_instr,        32'h1234_5678);
    bus1.ihit = 1'b0; bus1.h_pcen = 1'b0;

    // Back-to-back fetch of A, B, C, then one more to reach pc 0x10.
    do_reset();
    do_cycle(1'b1, 32'hA000_0001, 1'b1, 1'b0, 1'b0, '0);
    check("t1_npc4", bus0.ifid_npc, 32'd4);
    do_cycle(1'b1, 32'hB000_0002, 1'b1, 1'b0, 1'b0, '0);
    do_cycle(1'b1, 32'hC000_0003, 1'b1, 1'b0, 1'b0, '0);
    check("t1_instrC", bus0.ifid_instr, 32'hC000_0003);
    do_cycle(1'b1, 32'hD000_0004, 1'b1, 1'b0, 1'b0, '0);
    check("t2_pc10", bus0.imemaddr, 32'h10);

    // Hit during pause goes to the hold buffer; released when pause drops.
    do_cycle(1'b1, 32'hA0A0_A0A0, 1'b1, 1'b1, 1'b0, '0);
    do_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
    do_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    check("t2_instr", bus0.ifid_instr, 32'hA0A0_A0A0);
    check("t2_npc",   bus0.ifid_npc,   32'h14);

    // Redirect coincident with a hit drops the word.
    do_cycle(1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 32'h203);
    check("t3_addr", bus0.imemaddr, 32'h200);
    check("t3_valid", 32'(bus0.ifid_valid), 32'd0);

    // Redirect while holding under pause flushes the buffer.
    do_cycle(1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0, '0);
    do_cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h400);
    check("t4_addr", bus0.imemaddr, 32'h400);
    do_cycle(1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b0, '0);
    check("t4_instr", bus0.ifid_instr, 32'h3333_3333);

    // Halt: fetch stops, redirects ignored, bubble once pause drops, reset recovers.
    do_cycle(1'b1, 32'hFC00_0000, 1'b1, 1'b0, 1'b0, '0);
    check("t5_halted", 32'(bus0.fetch_halted), 32'd1);
    do_cycle(1'b1, 32'h4444_4444, 1'b1, 1'b1, 1'b1, 32'h800);
    check("t5_hold_word", bus0.ifid_instr, 32'hFC00_0000);
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h900);
    check("t5_bubble", 32'(bus0.ifid_valid), 32'd0);
    do_reset();
    check("t5_rst_addr", bus0.imemaddr, PC0);

    // Random traffic with occasional halts and asynchronous resets.
    for (int i = 0; i < 2500; i++) begin
      w = ($urandom % 250 == 0) ? {HALT_OP, 26'($urandom)} : rand_word();
      do_cycle(($urandom % 4) != 0, w, ($urandom % 5) != 0, ($urandom % 4) == 0,
               ($urandom % 12) == 0, $urandom);
      if ((m_halted && ($urandom % 6 == 0)) || ($urandom % 200 == 0)) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
